alu_seq_ctrl: RTL



---
 rtl/alu_seq_ctrl_if.sv | 40 ++++
 rtl/alu_seq_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Purpose: command, response and ALU-control bundle between decode, the
//          sequencer and the ALU datapath.
// Ports:   cmd_*  - valid/ready command channel (op, operands, immediate)
//          alu_*  - operand/mode/enable drive to the ALU and its result back
//          rsp_*  - valid/ready response channel (data, error flag)
// The slave modport is the sequencer's view; master is the surrounding system.
interface alu_seq_ctrl_if #(
  parameter int unsigned BUS_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [BUS_WIDTH-1:0] cmd_imm;
  logic [BUS_WIDTH-1:0] cmd_a;
  logic [BUS_WIDTH-1:0] cmd_b;

  logic [BUS_WIDTH-1:0] alu_data_a;
  logic [BUS_WIDTH-1:0] alu_data_b;
  logic [BUS_WIDTH-1:0] alu_imm;
  logic                 alu_f_add;
  logic [2:0]           alu_reg_en;
  logic [BUS_WIDTH-1:0] alu_result;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [BUS_WIDTH-1:0] rsp_data;
  logic                 rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_imm, cmd_a, cmd_b, alu_result, rsp_ready,
    output cmd_ready, alu_data_a, alu_data_b, alu_imm, alu_f_add, alu_reg_en,
           rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_imm, cmd_a, cmd_b, alu_result, rsp_ready,
    input  cmd_ready, alu_data_a, alu_data_b, alu_imm, alu_f_add, alu_reg_en,
           rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Purpose: command sequencer for the two-stage multiply/add ALU. Accepts one
//          operation, walks the ALU enables through LOAD/MULT/CAPT, captures
//          the result and returns it on the response channel.
// Ports:   clk, rst  - clock, asynchronous active-high reset
//          bus       - command/ALU/response bundle (slave view)
//          busy      - high whenever the sequencer is not idle
//          op_count  - completed responses, saturating
module alu_seq_ctrl #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_seq_ctrl_if.slave        bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] op_count
);

  localparam logic [1:0] OP_MAC  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;

  localparam logic [2:0] EN_LOAD = 3'b101;
  localparam logic [2:0] EN_MULT = 3'b010;
  localparam logic [2:0] EN_NONE = 3'b000;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MULT,
    S_CAPT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] a_q, a_d;
  logic [BUS_WIDTH-1:0] b_q, b_d;
  logic [BUS_WIDTH-1:0] imm_q, imm_d;
  logic                 f_add_q, f_add_d;
  logic [BUS_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic [2:0]           reg_en_q, reg_en_d;
  logic [CNT_WIDTH-1:0] op_count_q, op_count_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      f_add_q     <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      reg_en_q    <= EN_NONE;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      f_add_q     <= f_add_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      reg_en_q    <= reg_en_d;
      op_count_q  <= op_count_d;
    end
  end

  // Next-state, operand capture and response update
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    f_add_d    = f_add_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    op_count_d = op_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          imm_d   = bus.cmd_imm;
          f_add_d = (bus.cmd_op == OP_ADDI);
          unique case (bus.cmd_op)
            OP_MAC, OP_ADDI: state_d = S_LOAD;
            OP_CLR: begin
              rsp_data_d = '0;
              rsp_err_d  = 1'b0;
              state_d    = S_DONE;
            end
            default: begin
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
              state_d    = S_DONE;
            end
          endcase
        end
      end
      S_LOAD: state_d = S_MULT;
      S_MULT: state_d = S_CAPT;
      S_CAPT: begin
        rsp_data_d = bus.alu_result;
        rsp_err_d  = 1'b0;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
          if (op_count_q != CNT_MAX) begin
            op_count_d = op_count_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they leave flops
  // aligned with the state they describe.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    unique case (state_d)
      S_LOAD:  reg_en_d = EN_LOAD;
      S_MULT:  reg_en_d = EN_MULT;
      default: reg_en_d = EN_NONE;
    endcase
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.alu_data_a = a_q;
  assign bus.alu_data_b = b_q;
  assign bus.alu_imm    = imm_q;
  assign bus.alu_f_add  = f_add_q;
  assign bus.alu_reg_en = reg_en_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = busy_q;
  assign op_count       = op_count_q;

endmodule
